branch_resolve_queue: RTL

//  Update-side companion to the gshare global BHT. Fetch pushes each predicted

---
 rtl/branch_resolve_queue_if.sv | 52 +++++
 rtl/branch_resolve_queue.sv | 124 ++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue_if.sv
// branch_resolve_queue_if: fetch/resolve/BHT-update bundle for branch_resolve_queue.
// Signals: push/push_pc/push_pred (fetch enqueue), full/empty/count (occupancy),
//   resolve/resolve_pc/resolve_taken (resolution), bht_write/bht_write_pc/bht_taken
//   (BHT training), mispredict, sticky err_overflow/err_underflow/err_desync.
// Optional: BRQ_STATS_EN adds stat_resolved/stat_mispred.
// Modports: master = fetch/resolve side, slave = the queue.
interface branch_resolve_queue_if #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 16
);
    logic                   push;
    logic [PC_W-1:0]        push_pc;
    logic                   push_pred;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;
    logic                   resolve;
    logic [PC_W-1:0]        resolve_pc;
    logic                   resolve_taken;
    logic                   bht_write;
    logic [PC_W-1:0]        bht_write_pc;
    logic                   bht_taken;
    logic                   mispredict;
    logic                   err_overflow;
    logic                   err_underflow;
    logic                   err_desync;
`ifdef BRQ_STATS_EN
    logic [15:0]            stat_resolved;
    logic [15:0]            stat_mispred;
    modport master (
        output push, push_pc, push_pred, resolve, resolve_pc, resolve_taken,
        input  full, empty, count, bht_write, bht_write_pc, bht_taken, mispredict,
        input  err_overflow, err_underflow, err_desync, stat_resolved, stat_mispred
    );
    modport slave (
        input  push, push_pc, push_pred, resolve, resolve_pc, resolve_taken,
        output full, empty, count, bht_write, bht_write_pc, bht_taken, mispredict,
        output err_overflow, err_underflow, err_desync, stat_resolved, stat_mispred
    );
`else
    modport master (
        output push, push_pc, push_pred, resolve, resolve_pc, resolve_taken,
        input  full, empty, count, bht_write, bht_write_pc, bht_taken, mispredict,
        input  err_overflow, err_underflow, err_desync
    );
    modport slave (
        input  push, push_pc, push_pred, resolve, resolve_pc, resolve_taken,
        output full, empty, count, bht_write, bht_write_pc, bht_taken, mispredict,
        output err_overflow, err_underflow, err_desync
    );
`endif
endinterface

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order queue of predicted branches that trains the gshare BHT on resolution.
// Ports: clk, reset (sync, active-high), bus (branch_resolve_queue_if.slave) carrying
//   push/resolve requests in and occupancy, BHT training strobe, mispredict and sticky errors out.
// Optional: BRQ_STATS_EN adds saturating stat_resolved/stat_mispred counters.
module branch_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    branch_resolve_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full_q, full_d, empty_q, empty_d;
    logic [PC_W-1:0] mem_pc_q [DEPTH];
    logic [PC_W-1:0] mem_pc_d [DEPTH];
    logic            mem_pred_q [DEPTH];
    logic            mem_pred_d [DEPTH];
    logic            bht_write_q, bht_write_d, bht_taken_q, bht_taken_d;
    logic [PC_W-1:0] bht_pc_q, bht_pc_d;
    logic            mispredict_q, mispredict_d;
    logic            err_ov_q, err_ov_d, err_un_q, err_un_d, err_ds_q, err_ds_d;
    logic            pop, mis, do_push, head_pred;
    logic [PC_W-1:0] head_pc;

    always_comb begin
        head_pc      = mem_pc_q[head_q];
        head_pred    = mem_pred_q[head_q];
        pop          = bus.resolve && !empty_q;
        mis          = pop && (head_pred != bus.resolve_taken);
        // a push alongside a mispredict is wrong-path; a push into a full queue needs a same-cycle pop
        do_push      = bus.push && !mis && (!full_q || pop);
        head_d       = mis ? '0 : head_q + AW'(pop);
        tail_d       = mis ? '0 : tail_q + AW'(do_push);
        count_d      = mis ? '0 : count_q + CW'(do_push) - CW'(pop);
        full_d       = count_d == CW'(DEPTH);
        empty_d      = count_d == '0;
        mem_pc_d     = mem_pc_q;
        mem_pred_d   = mem_pred_q;
        if (do_push) begin
            mem_pc_d[tail_q]   = bus.push_pc;
            mem_pred_d[tail_q] = bus.push_pred;
        end
        bht_write_d  = pop;
        bht_pc_d     = pop ? head_pc : bht_pc_q;
        bht_taken_d  = pop ? bus.resolve_taken : bht_taken_q;
        mispredict_d = mis;
        err_ov_d     = err_ov_q | (bus.push && full_q && !bus.resolve);
        err_un_d     = err_un_q | (bus.resolve && empty_q);
        err_ds_d     = err_ds_q | (pop && bus.resolve_pc != head_pc);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            mem_pc_q     <= '{default: '0};
            mem_pred_q   <= '{default: 1'b0};
            bht_write_q  <= 1'b0;
            bht_pc_q     <= '0;
            bht_taken_q  <= 1'b0;
            mispredict_q <= 1'b0;
            err_ov_q     <= 1'b0;
            err_un_q     <= 1'b0;
            err_ds_q     <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            mem_pc_q     <= mem_pc_d;
            mem_pred_q   <= mem_pred_d;
            bht_write_q  <= bht_write_d;
            bht_pc_q     <= bht_pc_d;
            bht_taken_q  <= bht_taken_d;
            mispredict_q <= mispredict_d;
            err_ov_q     <= err_ov_d;
            err_un_q     <= err_un_d;
            err_ds_q     <= err_ds_d;
        end
    end

    assign bus.full          = full_q;
    assign bus.empty         = empty_q;
    assign bus.count         = count_q;
    assign bus.bht_write     = bht_write_q;
    assign bus.bht_write_pc  = bht_pc_q;
    assign bus.bht_taken     = bht_taken_q;
    assign bus.mispredict    = mispredict_q;
    assign bus.err_overflow  = err_ov_q;
    assign bus.err_underflow = err_un_q;
    assign bus.err_desync    = err_ds_q;

`ifdef BRQ_STATS_EN
    logic [15:0] stat_res_q, stat_res_d, stat_mis_q, stat_mis_d;

    // counters advance on the edge that raises the matching pulse
    always_comb begin
        stat_res_d = (pop && stat_res_q != 16'hFFFF) ? stat_res_q + 16'd1 : stat_res_q;
        stat_mis_d = (mis && stat_mis_q != 16'hFFFF) ? stat_mis_q + 16'd1 : stat_mis_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_res_q <= '0;
            stat_mis_q <= '0;
        end else begin
            stat_res_q <= stat_res_d;
            stat_mis_q <= stat_mis_d;
        end
    end

    assign bus.stat_resolved = stat_res_q;
    assign bus.stat_mispred  = stat_mis_q;
`endif
endmodule
